// File: rtl/m23_pkg.sv
// Shared definitions for the 2-or-3-of-4 line code: FSM encoding, codeword type,
// symbol-to-codeword map and the legality check used by transmit and receive sides.
package m23_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t SEND = 2'd1;
    localparam state_t GAP  = 2'd2;

    typedef logic [3:0] m23_word_t;

    localparam int unsigned M23_NUM_SYM = 10;

    // Legal words (popcount 2 or 3) in ascending order; out-of-range symbols map to 0.
    function automatic m23_word_t m23_encode(input logic [3:0] sym);
        m23_word_t word;
        case (sym)
            4'd0:    word = 4'b0011;
            4'd1:    word = 4'b0101;
            4'd2:    word = 4'b0110;
            4'd3:    word = 4'b0111;
            4'd4:    word = 4'b1001;
            4'd5:    word = 4'b1010;
            4'd6:    word = 4'b1011;
            4'd7:    word = 4'b1100;
            4'd8:    word = 4'b1101;
            4'd9:    word = 4'b1110;
            default: word = 4'b0000;
        endcase
        return word;
    endfunction

    function automatic logic m23_legal(input m23_word_t word);
        logic [2:0] ones;
        ones = 3'd0;
        for (int i = 0; i < 4; i++) begin
            ones = ones + {2'b00, word[i]};
        end
        return (ones == 3'd2) || (ones == 3'd3);
    endfunction

endpackage

// File: rtl/m23_bit_timer.sv
// Bit-time counter: while run is high, bit_tick marks the last cycle of each
// BIT_CYCLES-long bit-time. The count restarts whenever run is low.
module m23_bit_timer #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic nrst,
    input  logic run,
    output logic bit_tick
);

    localparam int unsigned CW = $clog2(BIT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    assign bit_tick = run && (cnt_q == CW'(BIT_CYCLES - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else if (!run || bit_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/m23_code_tx.sv
// 2-or-3-of-4 line-code transmitter: maps symbols 0..9 to legal codewords and sends them
// LSB-first on tx_bit. Optional macro M23_PARITY_EN appends an even-parity bit to each frame.
module m23_code_tx
    import m23_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned GAP_BITS   = 1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       in_valid,
    input  logic [3:0] in_sym,
    output logic       in_ready,
    output logic       tx_bit,
    output logic       tx_frame,
    output logic       err
);

`ifdef M23_PARITY_EN
    localparam int unsigned NBITS = 5;
`else
    localparam int unsigned NBITS = 4;
`endif

    localparam int unsigned MAXC     = (NBITS > GAP_BITS) ? NBITS : GAP_BITS;
    localparam int unsigned FW       = $clog2(MAXC + 1);
    localparam int unsigned GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   shift_q, shift_d;
    logic [FW-1:0]      cnt_q, cnt_d;
    logic               tx_bit_q, tx_bit_d;
    logic               tx_frame_q, tx_frame_d;
    logic               err_q, err_d;

    m23_word_t          code;
    logic [NBITS-1:0]   frame;
    logic               transfer;
    logic               sym_legal;
    logic               bit_tick;
    logic               last_bit;
    logic               last_gap;

    assign code = m23_encode(in_sym);

`ifdef M23_PARITY_EN
    assign frame = {^code, code};
`else
    assign frame = code;
`endif

    assign in_ready  = nrst && (state_q == IDLE);
    assign transfer  = in_valid && in_ready;
    assign sym_legal = in_sym < 4'(M23_NUM_SYM);
    assign last_bit  = cnt_q == FW'(NBITS - 1);
    assign last_gap  = cnt_q == FW'(GAP_LAST);

    m23_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk      (clk),
        .nrst     (nrst),
        .run      (state_q != IDLE),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_frame_d = tx_frame_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    if (sym_legal) begin
                        state_d    = SEND;
                        shift_d    = frame >> 1;
                        tx_bit_d   = frame[0];
                        tx_frame_d = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (bit_tick) begin
                    if (last_bit) begin
                        state_d    = (GAP_BITS > 0) ? GAP : IDLE;
                        tx_bit_d   = 1'b0;
                        tx_frame_d = 1'b0;
                        cnt_d      = '0;
                    end else begin
                        tx_bit_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (bit_tick) begin
                    if (last_gap) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                tx_bit_d   = 1'b0;
                tx_frame_d = 1'b0;
                cnt_d      = '0;
            end
        endcase
    end

    // Async reset drops the line mid-frame; the frame is abandoned.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            tx_bit_q   <= 1'b0;
            tx_frame_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_frame_q <= tx_frame_d;
            err_q      <= err_d;
        end
    end

    assign tx_bit   = tx_bit_q;
    assign tx_frame = tx_frame_q;
    assign err      = err_q;

    a_frame_not_ready: assert property (@(posedge clk) disable iff (!nrst)
        tx_frame |-> !in_ready);

    a_loaded_word_legal: assert property (@(posedge clk) disable iff (!nrst)
        (transfer && sym_legal) |-> m23_legal(code));

endmodule

// File: tb/tb_m23_code_tx.sv
// Bench for m23_code_tx: two instances (BIT_CYCLES 1 and 3, one gap bit each) checked
// every cycle against a schedule-queue model, plus directed literal frame checks.
module tb_m23_code_tx;

`ifdef M23_PARITY_EN
    localparam int NB = 5;
    localparam logic [4:0] W_SYM0 = 5'b00011;
    localparam logic [4:0] W_SYM3 = 5'b10111;
    localparam logic [4:0] W_SYM4 = 5'b01001;
    localparam logic [4:0] W_SYM5 = 5'b01010;
    localparam logic [4:0] W_SYM9 = 5'b11110;
`else
    localparam int NB = 4;
    localparam logic [4:0] W_SYM0 = 5'b00011;
    localparam logic [4:0] W_SYM3 = 5'b00111;
    localparam logic [4:0] W_SYM4 = 5'b01001;
    localparam logic [4:0] W_SYM5 = 5'b01010;
    localparam logic [4:0] W_SYM9 = 5'b01110;
`endif
    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       in_valid [2];
    logic [3:0] in_sym   [2];
    logic       rdy      [2];
    logic       txb      [2];
    logic       txf      [2];
    logic       errs     [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [3:0] code_tbl [10] = '{4'b0011, 4'b0101, 4'b0110, 4'b0111, 4'b1001,
                                  4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110};

    // Model: each accepted symbol appends one {frame,bit} entry per busy cycle.
    logic [1:0] sched [2][$];
    bit         busy    [2];
    bit         m_bit   [2];
    bit         m_frame [2];
    bit         m_err   [2];
    logic [4:0] fw;
    logic [1:0] e;

    always #5 clk = ~clk;

    m23_code_tx #(.BIT_CYCLES(1), .GAP_BITS(GAP)) dut0 (
        .clk      (clk),
        .nrst     (nrst),
        .in_valid (in_valid[0]),
        .in_sym   (in_sym[0]),
        .in_ready (rdy[0]),
        .tx_bit   (txb[0]),
        .tx_frame (txf[0]),
        .err      (errs[0])
    );

    m23_code_tx #(.BIT_CYCLES(3), .GAP_BITS(GAP)) dut1 (
        .clk      (clk),
        .nrst     (nrst),
        .in_valid (in_valid[1]),
        .in_sym   (in_sym[1]),
        .in_ready (rdy[1]),
        .tx_bit   (txb[1]),
        .tx_frame (txf[1]),
        .err      (errs[1])
    );

    function automatic int bc_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [4:0] frame_of(input logic [3:0] s);
        logic [3:0] c;
        c = code_tbl[s];
`ifdef M23_PARITY_EN
        return {^c, c};
`else
        return {1'b0, c};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!nrst) begin
                sched[i].delete();
                busy[i]    = 1'b0;
                m_bit[i]   = 1'b0;
                m_frame[i] = 1'b0;
                m_err[i]   = 1'b0;
            end else begin
                m_err[i] = 1'b0;
                if (in_valid[i] && !busy[i]) begin
                    if (in_sym[i] < 4'd10) begin
                        fw = frame_of(in_sym[i]);
                        for (int k = 0; k < NB; k++)
                            for (int c = 0; c < bc_of(i); c++)
                                sched[i].push_back({1'b1, fw[k]});
                        for (int g = 0; g < GAP * bc_of(i); g++)
                            sched[i].push_back(2'b00);
                    end else begin
                        m_err[i] = 1'b1;
                    end
                end
                if (sched[i].size() > 0) begin
                    e          = sched[i].pop_front();
                    m_frame[i] = e[1];
                    m_bit[i]   = e[0];
                    busy[i]    = 1'b1;
                end else begin
                    m_frame[i] = 1'b0;
                    m_bit[i]   = 1'b0;
                    busy[i]    = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("model_ready[%0d]", i), 32'(rdy[i]), 32'(nrst && !busy[i]));
            check($sformatf("model_bit[%0d]", i), 32'(txb[i]), 32'(nrst && m_bit[i]));
            check($sformatf("model_frame[%0d]", i), 32'(txf[i]), 32'(nrst && m_frame[i]));
            check($sformatf("model_err[%0d]", i), 32'(errs[i]), 32'(nrst && m_err[i]));
        end
    end

    // Returns #1 after the accepting edge; tcyc is that edge's cycle number.
    task automatic xfer(input int i, input logic [3:0] sym, input bit hold, output int tcyc);
        bit ok;
        ok = 1'b0;
        tcyc = 0;
        @(negedge clk);
        #1;
        in_valid[i] = 1'b1;
        in_sym[i]   = sym;
        for (int n = 0; n < 200; n++) begin
            if (rdy[i]) begin
                @(posedge clk);
                #1;
                tcyc = cyc;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!hold) in_valid[i] = 1'b0;
        check("xfer_handshake", 32'(ok), 32'd1);
    endtask

    task automatic grab(input int i, output logic [4:0] w);
        w = 5'b0;
        for (int k = 0; k < NB; k++) begin
            for (int c = 0; c < bc_of(i); c++) begin
                @(negedge clk);
                if (c == 0) w[k] = txb[i];
            end
        end
    endtask

    initial begin
        logic [4:0] w;
        logic [4:0] seen [10];
        int t1, t2;
        bit dup;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0;
            in_sym[i]   = 4'd0;
        end
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(rdy[0]), 32'd0);
        check("reset_bit", 32'(txb[0]), 32'd0);
        check("reset_frame", 32'(txf[0]), 32'd0);
        check("reset_err", 32'(errs[1]), 32'd0);
        #1 nrst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(rdy[0]), 32'd1);

        // sym 0: bits 1,1,0,0 then one gap cycle
        xfer(0, 4'd0, 1'b0, t1);
        grab(0, w);
        check("sym0_word", 32'(w), 32'(W_SYM0));
        @(negedge clk);
        check("sym0_gap_frame", 32'(txf[0]), 32'd0);
        check("sym0_gap_ready", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        check("sym0_idle_ready", 32'(rdy[0]), 32'd1);

        xfer(0, 4'd9, 1'b0, t1);
        grab(0, w);
        check("sym9_word", 32'(w), 32'(W_SYM9));

        for (int s = 0; s < 10; s++) begin
            xfer(0, 4'(s), 1'b0, t1);
            grab(0, w);
            seen[s] = w;
            check("sweep_legal", 32'(($countones(w[3:0]) == 2) || ($countones(w[3:0]) == 3)),
                  32'd1);
            dup = 1'b0;
            for (int j = 0; j < s; j++) if (seen[j][3:0] == w[3:0]) dup = 1'b1;
            check("sweep_distinct", 32'(dup), 32'd0);
        end

        // illegal symbol: one-cycle err, line idle, still ready
        xfer(0, 4'd12, 1'b0, t1);
        @(negedge clk);
        check("illegal_err", 32'(errs[0]), 32'd1);
        check("illegal_frame", 32'(txf[0]), 32'd0);
        check("illegal_ready", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        check("illegal_err_clear", 32'(errs[0]), 32'd0);

        // BIT_CYCLES=3 with valid held: 16-cycle frame period
        xfer(1, 4'd4, 1'b1, t1);
        grab(1, w);
        check("bc3_sym4_word", 32'(w), 32'(W_SYM4));
        xfer(1, 4'd4, 1'b0, t2);
        check("bc3_period", 32'(t2 - t1), 32'(1 + NB * 3 + GAP * 3));
        grab(1, w);
        check("bc3_sym4_word2", 32'(w), 32'(W_SYM4));

        // reset mid-frame while tx_bit is high
        xfer(0, 4'd5, 1'b0, t1);
        @(posedge clk);
        #1;
        check("midframe_bit_before", 32'(txb[0]), 32'd1);
        nrst = 1'b0;
        #1;
        check("midframe_bit_drop", 32'(txb[0]), 32'd0);
        check("midframe_frame_drop", 32'(txf[0]), 32'd0);
        check("midframe_ready_low", 32'(rdy[0]), 32'd0);
        repeat (2) @(negedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 32'(rdy[0]), 32'd1);
        check("post_reset_frame", 32'(txf[0]), 32'd0);
        xfer(0, 4'd5, 1'b0, t1);
        grab(0, w);
        check("post_reset_sym5", 32'(w), 32'(W_SYM5));

        xfer(0, 4'd3, 1'b0, t1);
        grab(0, w);
        check("sym3_word", 32'(w), 32'(W_SYM3));
        xfer(1, 4'd0, 1'b0, t1);
        grab(1, w);
        check("bc3_sym0_word", 32'(w), 32'(W_SYM0));

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
